// File: rtl/fact_accel_param.sv
// rtl/fact_accel_param.sv - iterative n! accelerator, one multiply per clock, overflow reported on err
module fact_accel_param #(
  parameter int N_WIDTH = 4,
  parameter int P_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  input  logic [N_WIDTH-1:0] n,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [P_WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, MULT, DONE, ERR} state_t;

  state_t                      state, state_nx;
  logic [N_WIDTH-1:0]          cnt, cnt_nx;
  logic [P_WIDTH-1:0]          result_nx;
  logic [P_WIDTH+N_WIDTH-1:0]  prod;
  logic                        ovf;

  // Full-width product so overflow is visible in the bits above P_WIDTH
  assign prod = {{N_WIDTH{1'b0}}, result} * {{P_WIDTH{1'b0}}, cnt};
  assign ovf  = |prod[P_WIDTH+N_WIDTH-1:P_WIDTH];

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    result_nx = result;
    if (abort) begin
      state_nx  = IDLE;
      cnt_nx    = '0;
      result_nx = '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (go) begin
            state_nx  = MULT;
            cnt_nx    = n;
            result_nx = P_WIDTH'(1);
          end
        end
        MULT: begin
          if (cnt <= N_WIDTH'(1)) begin
            state_nx = DONE;
          end else if (ovf) begin
            state_nx = ERR;
          end else begin
            result_nx = prod[P_WIDTH-1:0];
            cnt_nx    = cnt - N_WIDTH'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Status flags are flops fed from the next-state decode, so they change only on clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      result <= result_nx;
      busy   <= (state_nx == MULT);
      done   <= (state_nx == DONE);
      err    <= (state_nx == ERR);
    end
  end

endmodule

// File: tb/tb_fact_accel_param.sv
// tb/tb_fact_accel_param.sv - directed and random checks of fact_accel_param against a loop-based n! model
module tb_fact_accel_param;

  logic        clk;
  logic        rst;
  logic        go_a, abort_a;
  logic [3:0]  n_a;
  logic        busy_a, done_a, err_a;
  logic [31:0] result_a;
  logic        go_b, abort_b;
  logic [4:0]  n_b;
  logic        busy_b, done_b, err_b;
  logic [63:0] result_b;

  int n_cmp;
  int n_fail;

  fact_accel_param #(.N_WIDTH(4), .P_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .go(go_a), .abort(abort_a), .n(n_a),
    .busy(busy_a), .done(done_a), .err(err_a), .result(result_a)
  );

  fact_accel_param #(.N_WIDTH(5), .P_WIDTH(64)) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .abort(abort_b), .n(n_b),
    .busy(busy_b), .done(done_b), .err(err_b), .result(result_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // n! computed top-down, stopping at the first product that does not fit in pw bits
  function automatic void model(input int nv, input int pw, output logic [127:0] r,
                                output bit e, output int edges);
    logic [127:0] p;
    r = 128'd1;
    e = 1'b0;
    edges = 0;
    for (int c = nv; ; c--) begin
      edges++;
      if (c <= 1) break;
      p = r * c;
      if ((p >> pw) != 0) begin
        e = 1'b1;
        break;
      end
      r = p;
    end
  endfunction

  task automatic run_a(input int nv, input int glitch_edge, input string tag);
    logic [127:0] mr;
    bit           me;
    int           medges;
    int           edges;
    model(nv, 32, mr, me, medges);
    @(negedge clk);
    go_a = 1'b1;
    n_a  = 4'(nv);
    @(posedge clk);
    #1;
    check({tag, "_start_busy"}, busy_a, 1);
    check({tag, "_start_flags"}, {done_a, err_a}, 0);
    edges = 0;
    while (!(done_a || err_a) && edges < 200) begin
      @(negedge clk);
      if (edges + 1 == glitch_edge) begin
        go_a = 1'b1;
        n_a  = 4'd2;
      end else begin
        go_a = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    go_a = 1'b0;
    check({tag, "_latency"}, edges, medges);
    check({tag, "_done"}, done_a, !me);
    check({tag, "_err"}, err_a, me);
    check({tag, "_busy_end"}, busy_a, 0);
    check({tag, "_result"}, result_a, mr);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, {done_a, err_a, result_a}, {!me, me, mr[31:0]});
  endtask

  task automatic run_b(input int nv, input string tag);
    logic [127:0] mr;
    bit           me;
    int           medges;
    int           edges;
    model(nv, 64, mr, me, medges);
    @(negedge clk);
    go_b = 1'b1;
    n_b  = 5'(nv);
    @(posedge clk);
    #1;
    go_b = 1'b0;
    edges = 0;
    while (!(done_b || err_b) && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_latency"}, edges, medges);
    check({tag, "_flags"}, {done_b, err_b, busy_b}, {!me, me, 1'b0});
    check({tag, "_result"}, result_b, mr);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    go_a = 1'b0; abort_a = 1'b0; n_a = '0;
    go_b = 1'b0; abort_b = 1'b0; n_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {busy_a, done_a, err_a, result_a}, 0);
    check("reset_b", {busy_b, done_b, err_b, result_b}, 0);
    @(negedge clk);
    rst = 1'b1;

    run_a(5, -1, "n5");
    run_a(0, -1, "n0");
    run_a(1, -1, "n1_b2b");
    run_a(12, -1, "n12");
    check("n12_const", result_a, 32'h1C8CFC00);
    run_a(13, -1, "n13_ovf");
    run_a(3, -1, "n3_after_err");
    run_a(7, 2, "n7_go_ignored");
    check("n7_const", result_a, 5040);

    // abort at edge 3 of an n=15 run
    @(negedge clk);
    go_a = 1'b1; n_a = 4'd15;
    @(posedge clk);
    #1;
    go_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort_a = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_state", {done_a, err_a, result_a}, 0);
    @(negedge clk);
    go_a = 1'b1; n_a = 4'd4;
    @(posedge clk);
    #1;
    check("go_abort_idle", {busy_a, done_a, err_a, result_a}, 0);
    @(negedge clk);
    go_a = 1'b0; abort_a = 1'b0;

    // asynchronous reset between edges while multiplying
    @(negedge clk);
    go_a = 1'b1; n_a = 4'd9;
    @(posedge clk);
    #1;
    go_a = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", {busy_a, done_a, err_a, result_a}, 0);
    @(negedge clk);
    rst = 1'b1;

    run_b(20, "b_n20");
    check("b_n20_const", result_b, 64'd2432902008176640000);
    run_b(21, "b_n21_ovf");

    for (int i = 0; i < 16; i++) run_a(int'($urandom_range(0, 15)), -1, "rand_a");
    for (int i = 0; i < 8; i++) run_b(int'($urandom_range(0, 31)), "rand_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
